data_bus_arbiter: RTL

Two-master arbiter that shares the single `data_bus` port (address, rw, write data, read data) between the CPU and an auxiliary master such as a debug loader or DMA engine. It grants one master at a time, holds the bus stable for a fixed number of access cycles so the slow-clocked `data_bus` can complete, captures read data, and returns a one-cycle acknowledge. It sits between `zipocpu` and `data_bus` inside `ziposoc`.

---
 rtl/bus_arb_pkg.sv | 32 +++
 rtl/data_bus_arbiter_access_timer.sv | 33 +++
 rtl/data_bus_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the data_bus arbiter.
//   - state_e     : arbiter FSM states
//   - M_CPU/M_AUX : master indices (also the encoding of the owner output)
//   - RW_READ/RW_WRITE : rw encoding on masters and on the bus
//   - pick_winner : grant decision for one IDLE cycle
package bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   localparam logic M_CPU    = 1'b0;
   localparam logic M_AUX    = 1'b1;
   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   // A lone requester always wins. On a tie, round-robin hands the bus to
   // whichever master did not own it last; fixed priority favours the CPU.
   function automatic logic pick_winner(input logic req0,
                                        input logic req1,
                                        input logic last_owner,
                                        input logic rr_en);
      logic win;
      if (req0 && req1) win = rr_en ? ~last_owner : M_CPU;
      else if (req1)    win = M_AUX;
      else              win = M_CPU;
      return win;
   endfunction

endpackage

// File: rtl/data_bus_arbiter_access_timer.sv
// access_timer: loadable down-counter timing the ACCESS phase.
//   clk, rst_n    : clock, async active-low reset (count clears to 0)
//   load_i        : load load_val_i (has priority over dec_i)
//   load_val_i    : value to load
//   dec_i         : decrement by one
//   zero_o        : count is zero
module access_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)                      cnt_d = load_val_i;
      else if (dec_i && cnt_q != '0)   cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: shares one data_bus between the CPU (master 0) and an
// auxiliary master (master 1). A granted request is latched and driven on
// the bus for ACCESS_CYCLES cycles, read data is captured on the final
// access edge, and a one-cycle ack is returned to the winner.
//
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   mX_req/rw/addr/wdata           : master X request and fields (hold until ack)
//   mX_ack                         : one-cycle completion pulse
//   mX_rdata                       : captured read data, valid with ack
//   bus_rw/bus_addr/bus_write      : to data_bus
//   bus_read                       : from data_bus
//   bus_busy                       : high in ACCESS or DONE
//   owner                          : current / most recent grantee
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate masters on a tie;
// otherwise master 0 wins every tie.
module data_bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int ADDR_W        = 64,
   parameter int DATA_W        = 64,
   parameter int ACCESS_CYCLES = 4,
   parameter int CNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m0_rw,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_rw,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              bus_rw,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_write,
   input  logic [DATA_W-1:0] bus_read,
   output logic              bus_busy,
   output logic              owner
);

`ifdef ARB_ROUND_ROBIN_EN
   localparam logic RR_EN = 1'b1;
`else
   localparam logic RR_EN = 1'b0;
`endif

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ACCESS_CYCLES - 1);

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              rw_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;
   logic              ack0_q, ack1_q;

   logic tmr_load, tmr_dec, tmr_zero;
   logic grant, capture, ack_set;

   access_timer #(.CNT_W(CNT_W)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (LOAD_VAL),
      .dec_i      (tmr_dec),
      .zero_o     (tmr_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= M_AUX;  // so the CPU wins the first round-robin tie
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
      grant    = 1'b0;
      capture  = 1'b0;
      ack_set  = 1'b0;
      case (state_q)
         IDLE: begin
            if (m0_req || m1_req) begin
               owner_d  = pick_winner(m0_req, m1_req, owner_q, RR_EN);
               grant    = 1'b1;
               tmr_load = 1'b1;
               state_d  = ACCESS;
            end
         end
         ACCESS: begin
            if (tmr_zero) begin
               capture = 1'b1;
               state_d = DONE;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         DONE: begin
            ack_set = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath: fields are latched once at grant so the masters' live inputs
   // cannot disturb an access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rw_q     <= RW_READ;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
      end else begin
         if (grant) begin
            rw_q    <= (owner_d == M_AUX) ? m1_rw    : m0_rw;
            addr_q  <= (owner_d == M_AUX) ? m1_addr  : m0_addr;
            wdata_q <= (owner_d == M_AUX) ? m1_wdata : m0_wdata;
         end
         if (capture && rw_q == RW_READ) begin
            if (owner_q == M_AUX) rdata1_q <= bus_read;
            else                  rdata0_q <= bus_read;
         end
         ack0_q <= ack_set && (owner_q == M_CPU);
         ack1_q <= ack_set && (owner_q == M_AUX);
      end
   end

   // rw is gated by state so the bus never sees a write outside ACCESS.
   assign bus_rw    = (state_q == ACCESS) ? rw_q : RW_READ;
   assign bus_addr  = addr_q;
   assign bus_write = wdata_q;
   assign bus_busy  = (state_q != IDLE);
   assign owner     = owner_q;
   assign m0_ack    = ack0_q;
   assign m1_ack    = ack1_q;
   assign m0_rdata  = rdata0_q;
   assign m1_rdata  = rdata1_q;

endmodule
